// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   CLA_GROUP   : bits per lookahead group inside a chunk
//   REC_*       : bit offsets of the per-stage flag record (running carry,
//                 running propagate-AND, carry into the current chunk's MSB)
//   num_stages  : pipeline depth derived from operand width and chunk width
package adder_pkg;

    localparam int CLA_GROUP   = 4;

    localparam int REC_CARRY   = 0;
    localparam int REC_PROP    = 1;
    localparam int REC_CMSB    = 2;
    localparam int REC_FLAGS_W = 3;

    // Clamped to 1 so that an illegal configuration still elaborates far
    // enough for the top-level parameter check to report it.
    function automatic int num_stages(input int width, input int stage_bits);
        if (stage_bits < 1 || width < stage_bits) begin
            return 1;
        end
        return width / stage_bits;
    endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational BITS-wide carry-lookahead chunk.
//   a, b  : chunk operand bits
//   cin   : carry into bit 0 of the chunk
//   sum   : chunk sum bits
//   cout  : carry out of the chunk MSB
//   prop  : AND of all per-bit propagates (a ^ b)
//   cmsb  : carry into the chunk MSB (used for signed overflow)
// Carries inside each CLA_GROUP-bit group are formed directly from the group
// carry-in via prefix generate/propagate terms; groups are rippled.
module cla_chunk
    import adder_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] sum,
    output logic            cout,
    output logic            prop,
    output logic            cmsb
);

    logic [BITS-1:0] gen;
    logic [BITS-1:0] pro;
    logic [BITS-1:0] carry;

    assign gen = a & b;
    assign pro = a ^ b;

    always_comb begin
        logic grp_c;
        logic gacc;
        logic pacc;
        carry = '0;
        grp_c = cin;
        gacc  = 1'b0;
        pacc  = 1'b1;
        for (int gs = 0; gs < BITS; gs += CLA_GROUP) begin
            // gacc/pacc are the generate/propagate of bits [gs, j) so each
            // carry is a two-level function of the group carry-in.
            gacc = 1'b0;
            pacc = 1'b1;
            for (int j = 0; j < CLA_GROUP; j++) begin
                if (gs + j < BITS) begin
                    carry[gs+j] = gacc | (pacc & grp_c);
                    gacc        = gen[gs+j] | (pro[gs+j] & gacc);
                    pacc        = pacc & pro[gs+j];
                end
            end
            grp_c = gacc | (pacc & grp_c);
        end
        cout = grp_c;
    end

    assign sum  = pro ^ carry;
    assign prop = &pro;
    assign cmsb = carry[BITS-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit adder, one STAGE_BITS-wide CLA chunk per register stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake
//   sum                 : a + b + cin mod 2^WIDTH
//   cout                : carry out of the MSB
//   prop_all            : AND over all bits of a ^ b
//   ovf                 : signed overflow (carry into MSB xor cout)
// Each stage carries the unresolved operand bits, the already resolved sum
// bits, the running carry and the running propagate-AND to the next stage.
// Ready is a combinational bubble-collapsing chain from out_ready.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STAGE_BITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             prop_all,
    output logic             ovf
);

    localparam int STAGES = num_stages(WIDTH, STAGE_BITS);

    if (STAGE_BITS < 1) begin : g_bad_stage_bits
        $error("pipelined_cla_adder: STAGE_BITS must be >= 1");
    end else if (WIDTH % STAGE_BITS != 0) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of STAGE_BITS");
    end

    logic [STAGES:0]        ready;
    logic [STAGES-1:0]      vld_p;
    logic [WIDTH-1:0]       a_p   [STAGES];
    logic [WIDTH-1:0]       b_p   [STAGES];
    logic [WIDTH-1:0]       sum_p [STAGES];
    logic [REC_FLAGS_W-1:0] flg_p [STAGES];

    assign ready[STAGES] = out_ready;
    assign in_ready      = ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic                   vld_in;
        logic [WIDTH-1:0]       a_in;
        logic [WIDTH-1:0]       b_in;
        logic [WIDTH-1:0]       sum_in;
        logic                   carry_in;
        logic                   prop_in;
        logic [STAGE_BITS-1:0]  chunk_sum;
        logic                   chunk_cout;
        logic                   chunk_prop;
        logic                   chunk_cmsb;
        logic [WIDTH-1:0]       sum_nxt;
        logic [REC_FLAGS_W-1:0] flg_nxt;
        logic                   vld_r;
        logic [WIDTH-1:0]       a_r;
        logic [WIDTH-1:0]       b_r;
        logic [WIDTH-1:0]       sum_r;
        logic [REC_FLAGS_W-1:0] flg_r;

        if (k == 0) begin : g_first
            assign vld_in   = in_valid;
            assign a_in     = a;
            assign b_in     = b;
            assign sum_in   = '0;
            assign carry_in = cin;
            assign prop_in  = 1'b1;
        end else begin : g_next
            assign vld_in   = vld_p[k-1];
            assign a_in     = a_p[k-1];
            assign b_in     = b_p[k-1];
            assign sum_in   = sum_p[k-1];
            assign carry_in = flg_p[k-1][REC_CARRY];
            assign prop_in  = flg_p[k-1][REC_PROP];
        end

        cla_chunk #(
            .BITS (STAGE_BITS)
        ) u_chunk (
            .a    (a_in[k*STAGE_BITS +: STAGE_BITS]),
            .b    (b_in[k*STAGE_BITS +: STAGE_BITS]),
            .cin  (carry_in),
            .sum  (chunk_sum),
            .cout (chunk_cout),
            .prop (chunk_prop),
            .cmsb (chunk_cmsb)
        );

        always_comb begin
            sum_nxt                               = sum_in;
            sum_nxt[k*STAGE_BITS +: STAGE_BITS]   = chunk_sum;
            flg_nxt                               = '0;
            flg_nxt[REC_CARRY]                    = chunk_cout;
            flg_nxt[REC_PROP]                     = prop_in & chunk_prop;
            flg_nxt[REC_CMSB]                     = chunk_cmsb;
        end

        // Stage k register: loads whenever it is empty or its content moves on.
        // Data only updates with a valid item so the last result is held.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r <= 1'b0;
                a_r   <= '0;
                b_r   <= '0;
                sum_r <= '0;
                flg_r <= '0;
            end else if (ready[k]) begin
                vld_r <= vld_in;
                if (vld_in) begin
                    a_r   <= a_in;
                    b_r   <= b_in;
                    sum_r <= sum_nxt;
                    flg_r <= flg_nxt;
                end
            end
        end

        assign ready[k] = !vld_r | ready[k+1];
        assign vld_p[k] = vld_r;
        assign a_p[k]   = a_r;
        assign b_p[k]   = b_r;
        assign sum_p[k] = sum_r;
        assign flg_p[k] = flg_r;
    end

    assign out_valid = vld_p[STAGES-1];
    assign sum       = sum_p[STAGES-1];
    assign cout      = flg_p[STAGES-1][REC_CARRY];
    assign prop_all  = flg_p[STAGES-1][REC_PROP];
    assign ovf       = flg_p[STAGES-1][REC_CMSB] ^ flg_p[STAGES-1][REC_CARRY];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (WIDTH=32, STAGE_BITS=8): table of
// hand-computed vectors streamed back to back, then hand-written sequences
// for stalls, random back-pressure and mid-stream reset against a queue of
// expected results.
module tb_pipelined_cla_adder;

    localparam int W      = 32;
    localparam int SB     = 8;
    localparam int STAGES = W / SB;
    localparam int NV     = 13;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          prop_all;
    logic          ovf;

    pipelined_cla_adder #(
        .WIDTH      (W),
        .STAGE_BITS (SB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .prop_all  (prop_all),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         prop;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W+2:0] res;
        int           acc_cyc;
    } exp_t;

    vec_t tbl [NV];
    exp_t sb [$];
    int   n_applied = 0;
    int   n_miscmp  = 0;
    int   cyc       = 0;
    bit   chk_lat   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_applied++;
        if (act !== req) begin
            n_miscmp++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: plain wide addition; overflow from operand/result signs.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
        logic [W:0] s;
        logic       p;
        logic       o;
        s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        p = &(x ^ y);
        o = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        return {s[W-1:0], s[W], p, o};
    endfunction

    // One clock cycle: drive, settle, record handshakes, advance past edge.
    task automatic cycle(input bit iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input bit ordy, output bit acc);
        exp_t e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                check("result", {29'd0, sum, cout, prop_all, ovf}, {29'd0, sb[0].res});
                if (ordy) begin
                    if (chk_lat) check("latency", 64'(cyc - sb[0].acc_cyc), 64'(STAGES));
                    void'(sb.pop_front());
                end
            end
        end
        if (acc) begin
            e.res     = model(ia, ib, ic);
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("drain_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           acc;
        int           cnt;
        int           gaps;
        int           items;
        int           guard;
        logic [W-1:0] pa;
        logic [W-1:0] pb;
        logic         pc;

        tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{32'h0000FFFF, 32'hFFFF0000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_outputs", {29'd0, sum, cout, prop_all, ovf}, 64'd0);
        rst_n = 1'b1;

        // Table vectors streamed back to back; vector i appears STAGES cycles later.
        for (int n = 0; n < NV + STAGES; n++) begin
            if (n < NV) begin
                in_valid = 1'b1;
                a        = tbl[n].a;
                b        = tbl[n].b;
                cin      = tbl[n].cin;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (n < NV) check($sformatf("in_ready_vec%0d", n), {63'd0, in_ready}, 64'd1);
            @(posedge clk);
            #1;
            if (n >= STAGES - 1 && n - STAGES + 1 < NV) begin
                check($sformatf("vec%0d", n - STAGES + 1),
                      {28'd0, out_valid, sum, cout, prop_all, ovf},
                      {28'd0, 1'b1, tbl[n-STAGES+1].sum, tbl[n-STAGES+1].cout,
                       tbl[n-STAGES+1].prop, tbl[n-STAGES+1].ovf});
            end else begin
                check($sformatf("vec_idle_valid%0d", n), {63'd0, out_valid}, 64'd0);
            end
        end

        // Eight back-to-back random items, never stalled: fixed latency each.
        chk_lat = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, acc);
            if (acc) cnt++;
        end
        check("b2b_accepts", 64'(cnt), 64'd8);
        drain();
        chk_lat = 1'b0;

        // Output stalled with input pressing: exactly STAGES items fit.
        cnt = 0;
        pa = $urandom; pb = $urandom; pc = 1'($urandom_range(0, 1));
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, pa, pb, pc, 1'b0, acc);
            if (acc) begin
                cnt++;
                pa = $urandom; pb = $urandom; pc = 1'($urandom_range(0, 1));
            end
        end
        check("stall_accepts", 64'(cnt), 64'(STAGES));
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        gaps = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, pa, pb, pc, 1'b1, acc);
            if (!acc) gaps++;
            pa = $urandom; pb = $urandom; pc = 1'($urandom_range(0, 1));
        end
        check("release_gaps", 64'(gaps), 64'd0);
        drain();

        // Random valid / back-pressure for 1000 items.
        items = 0;
        guard = 0;
        pa = $urandom; pb = $urandom; pc = 1'($urandom_range(0, 1));
        while (items < 1000 && guard < 20000) begin
            cycle(($urandom_range(0, 3) != 0), pa, pb, pc, ($urandom_range(0, 3) != 0), acc);
            if (acc) begin
                items++;
                pa = $urandom; pb = $urandom; pc = 1'($urandom_range(0, 1));
            end
            guard++;
        end
        check("random_items", 64'(items), 64'd1000);
        drain();

        // Reset with three items in flight: none of them may emerge.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, acc);
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
        check("pre_reset_out_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_reset_outputs", {29'd0, sum, cout, prop_all, ovf}, 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        check("in_reset_out_valid", {63'd0, out_valid}, 64'd0);
        rst_n = 1'b1;
        chk_lat = 1'b1;
        cycle(1'b1, 32'h0F0F0F0F, 32'h01010101, 1'b1, 1'b1, acc);
        check("post_reset_accept", {63'd0, acc}, 64'd1);
        drain();
        chk_lat = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
        $finish;
    end

endmodule
